// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and types for the 640x480@60 Hz VGA timing generator.
//   Holds the default horizontal/vertical timing (visible, porches, sync),
//   the derived line/frame totals, the sync and visible window boundaries,
//   the 10-bit raster coordinate type and the registered output bundle.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing in pixels.
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  // Vertical timing in lines.
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Derived totals: 800 x 525 = 420000 pixel clocks per frame.
  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync windows are half-open [start, end): hsync 656..751, vsync 490..491.
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Raster coordinates are 10 bits wide (enough for 0..799 and 0..524).
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Registered per-pixel outputs, decoded one cycle early from the next
  // counter values so they line up with DrawX/DrawY.
  typedef struct packed {
    logic hs;           // active low
    logic vs;           // active low
    logic blank;        // 1 = visible region
    logic frame_start;  // 1 while at (0,0)
  } raster_out_t;

  localparam raster_out_t RASTER_OUT_RESET = '{
    hs:          1'b1,
    vs:          1'b1,
    blank:       1'b0,
    frame_start: 1'b0
  };

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_anim_ticker.sv
// ---------------------------------------------------------------------------
// vga_anim_ticker
//   Sprite animation frame index, stepped once every ANIM_DIV completed
//   display frames.
//
//   Ports
//     clk          in   pixel clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     frame_entry  in   1 on the edge whose next raster position is (0,0)
//     anim_en      in   1 = count completed frames, 0 = hold index/divider
//     anim_restart in   synchronous clear of index and divider (priority)
//     anim_frame   out  current animation frame index, 0..ANIM_FRAMES-1
//
//   The first frame entry after reset only arms the ticker (primed), because
//   no frame has been completed yet at that point.
// ---------------------------------------------------------------------------
module vga_anim_ticker #(
  parameter int ANIM_DIV    = 4,  // completed frames per step, >= 1
  parameter int ANIM_FRAMES = 8,  // index wraps to 0 after ANIM_FRAMES-1
  parameter int ANIM_W      = 4   // width of anim_frame
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_entry,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ANIM_W-1:0] anim_frame
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(ANIM_DIV - 1);
  localparam logic [ANIM_W-1:0] FRAME_LAST = ANIM_W'(ANIM_FRAMES - 1);

  logic [DIV_W-1:0]  div_q,    div_d;
  logic              primed_q, primed_d;
  logic [ANIM_W-1:0] frame_q,  frame_d;

  always_comb begin
    div_d    = div_q;
    primed_d = primed_q;
    frame_d  = frame_q;

    if (frame_entry) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (anim_en) begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + ANIM_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end

    // Restart wins over a coincident advance; primed is left alone so the
    // next frame entry still counts.
    if (anim_restart) begin
      div_d   = '0;
      frame_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      primed_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      div_q    <= div_d;
      primed_q <= primed_d;
      frame_q  <= frame_d;
    end
  end

  assign anim_frame = frame_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
//
//   Ports
//     vga_clk      in   pixel clock, all logic on the rising edge
//     reset_n      in   asynchronous active-low reset
//     anim_en      in   1 = animation index may advance
//     anim_restart in   synchronous clear of animation index and divider
//     DrawX        out  current pixel column, 0..H_TOTAL-1 (counter register)
//     DrawY        out  current line, 0..V_TOTAL-1 (counter register)
//     hs           out  horizontal sync, active low
//     vs           out  vertical sync, active low
//     blank        out  1 = visible region, 0 = blanking
//     frame_start  out  one-cycle pulse while (DrawX,DrawY) = (0,0)
//     anim_frame   out  sprite animation frame index
//
//   Reset parks the counters on the last pixel of the frame so the first
//   edge after release lands on (0,0) and starts a complete frame.
//   hs/vs/blank/frame_start are registered from the next counter values,
//   so they always describe the current DrawX/DrawY with no combinational
//   path from the counters to the pins.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int ANIM_DIV    = 4,
  parameter int ANIM_FRAMES = 8,
  parameter int ANIM_W      = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              frame_start,
  output logic [ANIM_W-1:0] anim_frame
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_END    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END    = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t      draw_x_q, draw_x_d;
  coord_t      draw_y_q, draw_y_d;
  raster_out_t out_q,    out_d;

  logic h_wrap;
  logic v_wrap;
  logic frame_entry;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    h_wrap      = (draw_x_q == H_LAST);
    v_wrap      = (draw_y_q == V_LAST);
    frame_entry = h_wrap && v_wrap;

    draw_x_d = h_wrap ? '0 : draw_x_q + coord_t'(1);
    draw_y_d = draw_y_q;
    if (h_wrap) begin
      draw_y_d = v_wrap ? '0 : draw_y_q + coord_t'(1);
    end

    // Decode from the next position so the registered flags align with the
    // counters they describe.
    out_d.hs          = !in_window(draw_x_d, H_SYNC_START, H_SYNC_END);
    out_d.vs          = !in_window(draw_y_d, V_SYNC_START, V_SYNC_END);
    out_d.blank       = (draw_x_d < H_VIS_END) && (draw_y_d < V_VIS_END);
    out_d.frame_start = frame_entry;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x_q <= H_LAST;
      draw_y_q <= V_LAST;
      out_q    <= RASTER_OUT_RESET;
    end else begin
      draw_x_q <= draw_x_d;
      draw_y_q <= draw_y_d;
      out_q    <= out_d;
    end
  end

  vga_anim_ticker #(
    .ANIM_DIV    (ANIM_DIV),
    .ANIM_FRAMES (ANIM_FRAMES),
    .ANIM_W      (ANIM_W)
  ) u_anim_ticker (
    .clk          (vga_clk),
    .rst_n        (reset_n),
    .frame_entry  (frame_entry),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .anim_frame   (anim_frame)
  );

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign hs          = out_q.hs;
  assign vs          = out_q.vs;
  assign blank       = out_q.blank;
  assign frame_start = out_q.frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock: hs, vs, blank and the DrawX/DrawY pixel coordinates.
- These are the coordinates consumed by the sprite-ROM renderers.
- Also produces a one-cycle frame_start strobe and a sprite animation frame index, so renderers can step through animation frames (e.g. the pulse sprite sheet) in lockstep with the display.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- ANIM_DIV, 4, completed frames per animation step (>=1)
- ANIM_FRAMES, 8, number of animation frames, wraps to 0 (>=1, <=2**ANIM_W)
- ANIM_W, 4, width of anim_frame

Ports:
- vga_clk  in  1  25 MHz pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- anim_en  in  1  1 = animation index may advance; 0 = hold index and divider
- anim_restart  in  1  synchronous clear of animation index and divider
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible region (drive colour), 0 = blanking
- frame_start  out  1  one-cycle pulse while (DrawX,DrawY)=(0,0)
- anim_frame  out  ANIM_W  current animation frame index

Behaviour:
- Derived totals: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Frame = 420000 cycles.
- DrawX/DrawY are the counter registers themselves.
- Each edge: DrawX increments. At H_TOTAL-1 it wraps to 0 and DrawY increments. DrawY wraps at V_TOTAL-1 only together with a DrawX wrap.
- hs, vs, blank and frame_start are registered and decoded from the next counter values, so on every cycle they describe the current DrawX/DrawY. There is no combinational path from counters to outputs.
- hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (lines 490..491). vs is independent of DrawX.
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Reset (async, reset_n=0) sets:
  - DrawX = H_TOTAL-1, DrawY = V_TOTAL-1 (799,524)
  - hs = 1, vs = 1, blank = 0, frame_start = 0
  - anim_frame = 0, divider = 0, primed = 0
- First rising edge after release therefore yields (0,0), blank = 1 and frame_start = 1, so the first full frame is never truncated.
- Animation: internal divider (0..ANIM_DIV-1) plus a primed flag.
  - Frame-entry event = edge whose next position is (0,0).
  - First entry after reset only sets primed = 1 and does not count.
  - Each later entry with anim_en = 1 counts one completed frame: if divider = ANIM_DIV-1, divider <- 0 and anim_frame advances, else divider increments.
  - anim_frame advances by +1 and wraps from ANIM_FRAMES-1 to 0.
  - anim_frame changes on the same edge frame_start rises, so it is stable for the whole frame.
  - anim_en = 0 at a frame entry: no count and no change. Raster timing is unaffected.
  - anim_restart = 1 on any edge: anim_frame <- 0 and divider <- 0. This has priority over a simultaneous advance. primed is unaffected.
  - ANIM_DIV = 1 advances at every counted entry. ANIM_FRAMES = 1 holds anim_frame at 0.
- Reset mid-frame: all outputs take reset values immediately, without waiting for a clock. After release, timing restarts at (0,0).

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (visible/porch/sync for H and V)
  - derived H_TOTAL/V_TOTAL
  - sync and visible window boundary constants
  - a coordinate typedef (10-bit)
- Sub-module vga_anim_ticker (divider + primed + anim_frame, driven by a frame-entry strobe, anim_en and anim_restart) is natural and separately testable. The raster counters and decode stay in the top.

Test Plan:
- Reset release: hold reset_n=0 for 3 edges, then release. Required: during reset (799,524), hs=1, vs=1, blank=0. First edge gives DrawX=0, DrawY=0, blank=1, frame_start=1, anim_frame=0. Next edge gives DrawX=1 and frame_start=0.
- Line timing, line 0:
  - blank=1 at DrawX=639, 0 at 640
  - hs falls at DrawX=656, rises at 752 (96 cycles low)
  - after DrawX=799, next edge gives DrawX=0, DrawY=1
- Frame timing:
  - blank=0 for all of DrawY=480..524
  - vs=0 exactly for DrawY=490 and 491 (1600 cycles)
  - DrawY=524, DrawX=799 wraps to (0,0) with frame_start=1
  - frame_start period exactly 420000 cycles
- Animation (ANIM_DIV=2, ANIM_FRAMES=3, anim_en=1): anim_frame at successive frame_starts = 0,0,1,1,2,2,0. With anim_en=0 across one frame entry, that entry is skipped and the sequence stretches by one frame.
- anim_restart=1 on the same edge an advance 1->2 would occur: anim_frame=0 and divider=0. The next advance comes ANIM_DIV counted entries later.
- Async reset mid-frame at DrawX=300, DrawY=200, anim_frame=2: outputs take reset values before the next clock edge. After release, the sequence restarts as in the reset-release test with anim_frame=0.
